// File: rtl/resp_misr_checker.sv
// Response compactor: folds one DUT response per vector into a MISR and
// compares against a golden signature. Optional watchdog: RESP_WATCHDOG_EN.
module resp_misr_checker #(
    parameter int          RESP_W      = 5,
    parameter int          SIG_W       = 16,
    parameter logic [15:0] POLY        = 16'h1021,
    parameter logic [15:0] SEED        = 16'hFFFF,
    parameter int          NUM_VECTORS = 512,
    parameter int          CNT_W       = 10,
    parameter int          TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              vec_valid,
    input  logic [RESP_W-1:0] resp,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_count,
    output logic              timeout,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_n;
    logic [SIG_W-1:0]   sig_n, sig_step;
    logic [CNT_W-1:0]   cnt_n;
    logic               pass_n;
    logic               last_vec;

    // Shift with feedback from the MSB, then inject the response word.
    assign sig_step = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? SIG_W'(POLY) : '0)
                    ^ SIG_W'(resp);
    assign last_vec = (vec_count == CNT_W'(NUM_VECTORS - 1));

`ifdef RESP_WATCHDOG_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic              to_n;
`endif

    always_comb begin
        state_n = state;
        sig_n   = signature;
        cnt_n   = vec_count;
        pass_n  = pass;
`ifdef RESP_WATCHDOG_EN
        idle_n  = idle_cnt;
        to_n    = timeout;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = COLLECT;
                    sig_n   = SIG_W'(SEED);
                    cnt_n   = '0;
                    pass_n  = 1'b0;
`ifdef RESP_WATCHDOG_EN
                    idle_n  = '0;
                    to_n    = 1'b0;
`endif
                end
            end
            COLLECT: begin
                if (start) begin
                    // Restart wins; a coincident vec_valid is dropped.
                    sig_n  = SIG_W'(SEED);
                    cnt_n  = '0;
                    pass_n = 1'b0;
`ifdef RESP_WATCHDOG_EN
                    idle_n = '0;
                    to_n   = 1'b0;
`endif
                end else if (vec_valid) begin
                    sig_n = sig_step;
                    cnt_n = vec_count + 1'b1;
`ifdef RESP_WATCHDOG_EN
                    idle_n = '0;
`endif
                    if (last_vec) begin
                        state_n = DONE;
                        pass_n  = (sig_step == golden_sig);
                    end
                end
`ifdef RESP_WATCHDOG_EN
                else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    state_n = DONE;
                    to_n    = 1'b1;
                    pass_n  = 1'b0;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= SIG_W'(SEED);
            vec_count <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            signature <= sig_n;
            vec_count <= cnt_n;
            pass      <= pass_n;
        end
    end

`ifdef RESP_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            idle_cnt <= idle_n;
            timeout  <= to_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign busy      = (state == COLLECT);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
